pll_lock_supervisor: RTL and testbench

//   Sequences the 50->100 MHz PLL. Pulses the PLL reset, waits for a stable lock, and releases the

---
 rtl/pll_sup_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 137 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state codes and widths for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int unsigned LOL_W = 8;
    localparam int unsigned ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        ST_RESET_PLL = 3'b000,
        ST_WAIT_LOCK = 3'b001,
        ST_STABILIZE = 3'b010,
        ST_RUN       = 3'b011,
        ST_FAULT     = 3'b100
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to resolve metastability on the incoming level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, releases system reset,
// retries on timeout and latches a fault after the retry budget is spent.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned CNT_W            = 20
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [ST_W-1:0]  state_o,
    output logic [LOL_W-1:0] lol_count
);

    localparam int unsigned STAB_W  = $clog2(LOCK_STABLE_CYC + 1);
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tmo_cnt, tmo_nx, tmo_inc;
    logic [STAB_W-1:0]  stab_cnt, stab_nx;
    logic [RETRY_W-1:0] retry_cnt, retry_nx;
    logic [LOL_W-1:0]   lol_nx;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Timer saturates so repeated lock bounces cannot wrap it back under the limit
    assign tmo_inc = (&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_W'(1);

    // State and counter registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET_PLL;
            tmo_cnt   <= '0;
            stab_cnt  <= '0;
            retry_cnt <= '0;
            lol_count <= '0;
        end else begin
            state     <= state_nx;
            tmo_cnt   <= tmo_nx;
            stab_cnt  <= stab_nx;
            retry_cnt <= retry_nx;
            lol_count <= lol_nx;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        stab_nx  = stab_cnt;
        retry_nx = retry_cnt;
        lol_nx   = lol_count;
        unique case (state)
            ST_RESET_PLL: begin
                // tmo_cnt doubles as the pulse-width counter here
                if (tmo_cnt >= CNT_W'(RST_PULSE_CYC - 1)) begin
                    state_nx = ST_WAIT_LOCK;
                    tmo_nx   = '0;
                end else begin
                    tmo_nx = tmo_inc;
                end
            end
            ST_WAIT_LOCK: begin
                tmo_nx = tmo_inc;
                if (lock_s) begin
                    state_nx = ST_STABILIZE;
                    stab_nx  = '0;
                end else if (tmo_cnt >= CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    tmo_nx = '0;
                    if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
                        state_nx = ST_FAULT;
                    end else begin
                        retry_nx = retry_cnt + RETRY_W'(1);
                        state_nx = ST_RESET_PLL;
                    end
                end
            end
            ST_STABILIZE: begin
                // Timer keeps running so a bounce back to WAIT_LOCK keeps the original deadline
                tmo_nx = tmo_inc;
                if (!lock_s) begin
                    state_nx = ST_WAIT_LOCK;
                end else if (stab_cnt == STAB_W'(LOCK_STABLE_CYC - 1)) begin
                    state_nx = ST_RUN;
                    retry_nx = '0;
                end else begin
                    stab_nx = stab_cnt + STAB_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s && !(&lol_count)) begin
                    lol_nx = lol_count + LOL_W'(1);
                end
                if (!lock_s || force_relock) begin
                    state_nx = ST_RESET_PLL;
                    tmo_nx   = '0;
                end
            end
            ST_FAULT: begin
                if (force_relock) begin
                    state_nx = ST_RESET_PLL;
                    retry_nx = '0;
                    tmo_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_RESET_PLL;
                tmo_nx   = '0;
                stab_nx  = '0;
                retry_nx = '0;
            end
        endcase
    end

    // Outputs decoded straight from the state register so async reset takes effect at once
    assign pll_rst   = (state == ST_RESET_PLL) || (state == ST_FAULT);
    assign sys_rst_n = (state == ST_RUN);
    assign ready     = (state == ST_RUN);
    assign fault     = (state == ST_FAULT);
    assign state_o   = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: table checkpoints, directed corner
// sequences and a randomized run against a timestamp-based reference model.
module tb_pll_lock_supervisor;

    localparam int RST_PULSE = 4;
    localparam int TMO       = 100;
    localparam int STAB      = 8;
    localparam int MAXR      = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst, sys_rst_n, ready, fault;
    logic [2:0] state_o;
    logic [7:0] lol_count;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    // Reference model: phase code plus timestamps, lock seen through a 2-deep delay queue
    int m_ph, m_start, m_release, m_retry, m_lol;
    bit lq[$];

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (RST_PULSE),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STAB),
        .MAX_RETRIES      (MAXR),
        .CNT_W            (20)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fault        (fault),
        .state_o      (state_o),
        .lol_count    (lol_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int act_vec();
        return int'({state_o, pll_rst, sys_rst_n, ready, fault, lol_count});
    endfunction

    function automatic int exp_vec(input int ph, input int lol);
        logic prst, srn, rdy, flt;
        prst = (ph == 0) || (ph == 4);
        srn  = (ph == 3);
        rdy  = (ph == 3);
        flt  = (ph == 4);
        return int'({3'(ph), prst, srn, rdy, flt, 8'(lol)});
    endfunction

    task automatic model_init();
        m_ph = 0; m_start = 0; m_release = 0; m_retry = 0; m_lol = 0;
        lq = {1'b0, 1'b0};
        n = 0;
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare outputs
    task automatic step(input logic p, input logic f);
        bit ls;
        int e, nph;
        pll_locked   = p;
        force_relock = f;
        ls  = lq[0];
        e   = n - m_start;
        nph = m_ph;
        case (m_ph)
            0: if (e >= RST_PULSE - 1) begin nph = 1; m_release = n + 1; end
            1: begin
                if (ls) nph = 2;
                else if (n - m_release >= TMO - 1) begin
                    if (m_retry == MAXR) nph = 4;
                    else begin m_retry++; nph = 0; end
                end
            end
            2: begin
                if (!ls) nph = 1;
                else if (e == STAB - 1) begin nph = 3; m_retry = 0; end
            end
            3: begin
                if (!ls && m_lol < 255) m_lol++;
                if (!ls || f) nph = 0;
            end
            4: if (f) begin nph = 0; m_retry = 0; end
            default: nph = 0;
        endcase
        if (nph != m_ph) m_start = n + 1;
        m_ph = nph;
        lq.push_back(p);
        void'(lq.pop_front());
        @(posedge refclk);
        #1;
        n++;
        chk($sformatf("model cyc%0d", n), act_vec(), exp_vec(m_ph, m_lol));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
        @(posedge refclk);
        #1;
        chk("reset_hold", act_vec(), exp_vec(0, 0));
        rst_n = 1'b1;
        model_init();
        chk("reset_release", act_vec(), exp_vec(0, 0));
    endtask

    // Assert reset between edges and expect reset outputs without waiting for a clock
    task automatic async_rst(input string name);
        #2 rst_n = 1'b0;
        #1;
        chk(name, act_vec(), exp_vec(0, 0));
        do_reset();
    endtask

    task automatic wait_ready(input string name, input int maxc);
        int k = 0;
        while (ready !== 1'b1 && k < maxc) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk(name, int'(ready), 1);
    endtask

    function automatic logic lock_rule(input int scen, input int cyc);
        if (scen == 1) return (cyc >= 20);
        return 1'b0;
    endfunction

    typedef struct {
        int         scen;
        int         cyc;
        logic [2:0] st;
        logic       prst;
        logic       srn;
        logic       rdy;
        logic       flt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int cur, cnt, seg, lvl;
        logic f;
        // scen 1: lock from cycle 20; scen 2: lock never asserts
        tbl[0]  = '{1,   0, 3'd0, 1, 0, 0, 0};
        tbl[1]  = '{1,   3, 3'd0, 1, 0, 0, 0};
        tbl[2]  = '{1,   4, 3'd1, 0, 0, 0, 0};
        tbl[3]  = '{1,  22, 3'd1, 0, 0, 0, 0};
        tbl[4]  = '{1,  23, 3'd2, 0, 0, 0, 0};
        tbl[5]  = '{1,  30, 3'd2, 0, 0, 0, 0};
        tbl[6]  = '{1,  31, 3'd3, 0, 1, 1, 0};
        tbl[7]  = '{1,  45, 3'd3, 0, 1, 1, 0};
        tbl[8]  = '{2, 103, 3'd1, 0, 0, 0, 0};
        tbl[9]  = '{2, 104, 3'd0, 1, 0, 0, 0};
        tbl[10] = '{2, 107, 3'd0, 1, 0, 0, 0};
        tbl[11] = '{2, 108, 3'd1, 0, 0, 0, 0};
        tbl[12] = '{2, 208, 3'd0, 1, 0, 0, 0};
        tbl[13] = '{2, 211, 3'd0, 1, 0, 0, 0};
        tbl[14] = '{2, 212, 3'd1, 0, 0, 0, 0};
        tbl[15] = '{2, 311, 3'd1, 0, 0, 0, 0};
        tbl[16] = '{2, 312, 3'd4, 1, 0, 0, 1};
        tbl[17] = '{2, 400, 3'd4, 1, 0, 0, 1};

        rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
        cur = 0;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].scen != cur) begin
                do_reset();
                cur = tbl[i].scen;
            end
            while (n < tbl[i].cyc) step(lock_rule(cur, n), 1'b0);
            chk($sformatf("tbl s%0d c%0d", tbl[i].scen, tbl[i].cyc), act_vec() >> 8,
                int'({tbl[i].st, tbl[i].prst, tbl[i].srn, tbl[i].rdy, tbl[i].flt}));
        end

        // FAULT exit on force_relock gives exactly one fresh 4-cycle pulse
        step(1'b0, 1'b1);
        chk("fault_exit_state", int'(state_o), 0);
        chk("fault_exit_flag", int'(fault), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("relock_pulse_last", int'(pll_rst), 1);
        step(1'b0, 1'b0);
        chk("relock_pulse_end", int'({state_o, pll_rst}), int'({3'd1, 1'b0}));

        // Single-cycle glitch during STABILIZE restarts the full window
        do_reset();
        while (n < 28) begin
            step((n >= 10) && (n != 15), 1'b0);
            if (n == 18) chk("glitch_back_wait", int'(state_o), 1);
            if (n == 19) chk("glitch_restab", int'(state_o), 2);
            if (n == 26) chk("glitch_not_ready", int'(ready), 0);
            if (n == 27) chk("glitch_ready", int'(ready), 1);
        end

        // Loss of lock in RUN for 3 cycles
        do_reset();
        wait_ready("lol_first_ready", 40);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("lol_sys_rst_low", int'(sys_rst_n), 0);
        chk("lol_count_1", int'(lol_count), 1);
        wait_ready("lol_reready", 60);

        // Lock drop and force_relock in the same synced cycle
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("both_state", int'(state_o), 0);
        chk("both_lol_once", int'(lol_count), 2);
        cnt = pll_rst ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (pll_rst) cnt++;
        end
        chk("both_one_pulse", cnt, RST_PULSE);

        // 256 further losses saturate the counter
        for (int i = 0; i < 256; i++) begin
            wait_ready($sformatf("sat_ready%0d", i), 60);
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
        end
        chk("lol_saturated", int'(lol_count), 255);
        wait_ready("sat_final_ready", 60);
        async_rst("async_rst_in_run");

        // Async reset mid-STABILIZE, then restart from RESET_PLL
        while (n < 8) step(1'b1, 1'b0);
        chk("mid_stab_state", int'(state_o), 2);
        async_rst("async_rst_in_stab");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("restart_wait", int'(state_o), 1);

        // Randomized segments of lock/unlock with sporadic force_relock
        do_reset();
        seg = 0; lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                lvl = ($urandom_range(0, 3) != 0) ? 1 : 0;
                if (lvl == 1) seg = $urandom_range(5, 60);
                else seg = ($urandom_range(0, 4) == 0) ? $urandom_range(90, 350)
                                                       : $urandom_range(1, 6);
            end
            seg--;
            f = ($urandom_range(0, 39) == 0);
            step(lvl[0], f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
